vga_move_ctrl: RTL and testbench

- Upstream control stage for the VGA output block. Owns the moving box's position (pos_x, pos_y) and its 8-bit RGB332 colour (data), which feed the VGA block's data input and box-compare logic.
- Position is moved by debounced push-buttons in MANUAL mode, or bounces off the screen edges in AUTO mode.
- All updates are applied once per frame on frame_tick, so the picture never tears mid-frame.

---
 rtl/vga_move_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_vga_move_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_move_ctrl.sv
// -----------------------------------------------------------------------------
// vga_move_ctrl
//   Upstream control stage for the VGA output block. It owns the moving box's
//   top-left position and its RGB332 colour. In MANUAL mode, debounced
//   push-buttons move the box. In AUTO mode, the box bounces off the screen
//   edges and rotates its colour on every bounce. Position and colour change
//   only on frame_tick, so the picture never tears mid-frame.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   frame_tick in   1   one-cycle pulse per frame (start of vertical blank)
//   btn_up     in   1   raw asynchronous button, active-high
//   btn_down   in   1   raw asynchronous button, active-high
//   btn_left   in   1   raw asynchronous button, active-high
//   btn_right  in   1   raw asynchronous button, active-high
//   btn_mode   in   1   raw asynchronous button, toggles MANUAL/AUTO
//   pos_x      out 10   box left edge, 0..H_ACTIVE-BOX_SIZE
//   pos_y      out 10   box top edge, 0..V_ACTIVE-BOX_SIZE
//   data       out  8   box colour (RGB332)
//   auto_mode  out  1   1 = AUTO, 0 = MANUAL
// -----------------------------------------------------------------------------
module vga_move_ctrl #(
  parameter int          H_ACTIVE        = 640,
  parameter int          V_ACTIVE        = 480,
  parameter int          BOX_SIZE        = 32,
  parameter int          STEP            = 2,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [7:0]  INIT_COLOR      = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_mode,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [7:0] data,
  output logic       auto_mode
);

  localparam int XMAX    = H_ACTIVE - BOX_SIZE;
  localparam int YMAX    = V_ACTIVE - BOX_SIZE;
  localparam int NUM_BTN = 5;
  // The counter only ever has to hold DEBOUNCE_CYCLES-1.
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [10:0] XMAX_S  = 11'(XMAX);
  localparam logic signed [10:0] YMAX_S  = 11'(YMAX);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] ZERO_S  = 11'sd0;

  // Bit positions of each button in the synchroniser and debouncer vectors.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_MODE  = 4;

  // Result of one axis update.
  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       bounce;
  } axis_t;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_deb;
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];

  assign w_btn_raw = {btn_mode, btn_right, btn_left, btn_down, btn_up};

  // NOTE: all sequential state uses non-blocking assignments. Every flop then
  // samples its pre-edge value, so the two synchroniser stages do not collapse
  // into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM. Each entry is
      // cleared explicitly so every debouncer starts from a known state.
      for (int i = 0; i < NUM_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Axis helpers (11-bit signed so that the edge tests never wrap)
  // ---------------------------------------------------------------------------
  function automatic axis_t manual_axis(input logic [9:0] pos,
                                        input logic       inc,
                                        input logic       dec,
                                        input logic signed [10:0] lim);
    axis_t              r;
    logic signed [10:0] p;
    logic signed [10:0] sum;
    logic signed [10:0] diff;
    p        = signed'({1'b0, pos});
    sum      = p + STEP_S;
    diff     = p - STEP_S;
    r.pos    = pos;
    r.dir    = 1'b0;
    r.bounce = 1'b0;
    if (inc && !dec) begin
      r.pos = (sum > lim) ? lim[9:0] : sum[9:0];
    end else if (dec && !inc) begin
      r.pos = (diff < ZERO_S) ? 10'd0 : diff[9:0];
    end
    return r;
  endfunction

  function automatic axis_t auto_axis(input logic [9:0] pos,
                                      input logic       dir,
                                      input logic signed [10:0] lim);
    axis_t              r;
    logic signed [10:0] p;
    logic signed [10:0] sum;
    logic signed [10:0] diff;
    p        = signed'({1'b0, pos});
    sum      = p + STEP_S;
    diff     = p - STEP_S;
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (dir) begin
      if (sum >= lim) begin
        r.pos    = lim[9:0];
        r.dir    = 1'b0;
        r.bounce = 1'b1;
      end else begin
        r.pos = sum[9:0];
      end
    end else begin
      if (diff <= ZERO_S) begin
        r.pos    = 10'd0;
        r.dir    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = diff[9:0];
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame update
  // ---------------------------------------------------------------------------
  logic [9:0] r_pos_x;
  logic [9:0] r_pos_y;
  logic [7:0] r_data;
  logic       r_auto;
  logic       r_dir_x;
  logic       r_dir_y;
  logic       r_mode_prev;

  axis_t      w_ax;
  axis_t      w_ay;
  logic [9:0] w_nxt_x;
  logic [9:0] w_nxt_y;
  logic [7:0] w_nxt_data;
  logic       w_nxt_dir_x;
  logic       w_nxt_dir_y;
  logic       w_mode_rise;

  assign w_mode_rise = r_deb[BTN_MODE] & ~r_mode_prev;

  // NOTE: every signal written here gets a default first. Otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    w_nxt_x     = r_pos_x;
    w_nxt_y     = r_pos_y;
    w_nxt_data  = r_data;
    w_nxt_dir_x = r_dir_x;
    w_nxt_dir_y = r_dir_y;
    w_ax        = '0;
    w_ay        = '0;
    if (frame_tick) begin
      if (r_auto) begin
        w_ax        = auto_axis(r_pos_x, r_dir_x, XMAX_S);
        w_ay        = auto_axis(r_pos_y, r_dir_y, YMAX_S);
        w_nxt_x     = w_ax.pos;
        w_nxt_y     = w_ay.pos;
        w_nxt_dir_x = w_ax.dir;
        w_nxt_dir_y = w_ay.dir;
        // One rotation per tick, even when both axes bounce together.
        if (w_ax.bounce || w_ay.bounce) w_nxt_data = {r_data[6:0], r_data[7]};
      end else begin
        w_ax    = manual_axis(r_pos_x, r_deb[BTN_RIGHT], r_deb[BTN_LEFT], XMAX_S);
        w_ay    = manual_axis(r_pos_y, r_deb[BTN_DOWN], r_deb[BTN_UP], YMAX_S);
        w_nxt_x = w_ax.pos;
        w_nxt_y = w_ay.pos;
      end
    end
  end

  // A mode edge updates r_auto at the same clock edge that applies the frame
  // update. That update has already been computed from the old mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos_x     <= 10'(XMAX / 2);
      r_pos_y     <= 10'(YMAX / 2);
      r_data      <= INIT_COLOR;
      r_auto      <= 1'b0;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_mode_prev <= 1'b0;
    end else begin
      r_pos_x     <= w_nxt_x;
      r_pos_y     <= w_nxt_y;
      r_data      <= w_nxt_data;
      r_dir_x     <= w_nxt_dir_x;
      r_dir_y     <= w_nxt_dir_y;
      r_mode_prev <= r_deb[BTN_MODE];
      if (w_mode_rise) r_auto <= ~r_auto;
    end
  end

  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign data      = r_data;
  assign auto_mode = r_auto;

endmodule

// File: tb/tb_vga_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_move_ctrl
//   Self-checking bench for vga_move_ctrl, run with a short debounce window.
//   A behavioural model predicts the box state for each frame tick. The
//   prediction is queued when the tick is driven, then popped and compared
//   once the registered outputs have updated. Fixed values from the test plan
//   are checked as well.
// -----------------------------------------------------------------------------
module tb_vga_move_ctrl;

  localparam int D    = 4;
  localparam int XMAX = 608;
  localparam int YMAX = 448;
  localparam int STEP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right, btn_mode;
  logic [9:0] pos_x, pos_y;
  logic [7:0] data;
  logic       auto_mode;

  always #5 clk = ~clk;

  vga_move_ctrl #(
    .H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(32), .STEP(STEP),
    .DEBOUNCE_CYCLES(D), .INIT_COLOR(8'hE0)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_mode(btn_mode),
    .pos_x(pos_x), .pos_y(pos_y), .data(data), .auto_mode(auto_mode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state, plus the button levels the bench has let settle.
  int         m_x, m_y;
  bit         m_dx, m_dy, m_auto;
  logic [7:0] m_data;
  bit         db_up, db_down, db_left, db_right;

  typedef struct {
    string      tag;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] d;
    logic       a;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_reset();
    m_x = XMAX / 2; m_y = YMAX / 2; m_dx = 1; m_dy = 1;
    m_auto = 0; m_data = 8'hE0;
    db_up = 0; db_down = 0; db_left = 0; db_right = 0;
  endtask

  task automatic model_tick();
    bit bounced;
    bounced = 0;
    if (m_auto) begin
      if (m_dx) begin
        if (m_x + STEP >= XMAX) begin m_x = XMAX; m_dx = 0; bounced = 1; end
        else m_x = m_x + STEP;
      end else begin
        if (m_x - STEP <= 0) begin m_x = 0; m_dx = 1; bounced = 1; end
        else m_x = m_x - STEP;
      end
      if (m_dy) begin
        if (m_y + STEP >= YMAX) begin m_y = YMAX; m_dy = 0; bounced = 1; end
        else m_y = m_y + STEP;
      end else begin
        if (m_y - STEP <= 0) begin m_y = 0; m_dy = 1; bounced = 1; end
        else m_y = m_y - STEP;
      end
      if (bounced) m_data = {m_data[6:0], m_data[7]};
    end else begin
      if (db_right && !db_left) m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
      if (db_left && !db_right) m_x = (m_x - STEP < 0) ? 0 : m_x - STEP;
      if (db_down && !db_up)    m_y = (m_y + STEP > YMAX) ? YMAX : m_y + STEP;
      if (db_up && !db_down)    m_y = (m_y - STEP < 0) ? 0 : m_y - STEP;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.x   = 10'(m_x);
    e.y   = 10'(m_y);
    e.d   = m_data;
    e.a   = m_auto;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".x"},    32'(pos_x),     32'(e.x));
      check({e.tag, ".y"},    32'(pos_y),     32'(e.y));
      check({e.tag, ".data"}, 32'(data),      32'(e.d));
      check({e.tag, ".auto"}, 32'(auto_mode), 32'(e.a));
    end
  endtask

  task automatic check_state(input string tag);
    push_exp(tag);
    pop_cmp();
  endtask

  task automatic do_tick(input string tag);
    @(posedge clk); #1;
    frame_tick = 1'b1;
    model_tick();
    push_exp(tag);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    pop_cmp();
  endtask

  // Drive the button levels and wait until they have passed the debouncer.
  task automatic set_buttons(input bit u, input bit d, input bit l, input bit r, input bit m);
    @(posedge clk); #1;
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_mode = m;
    repeat (D + 4) @(posedge clk);
    db_up = u; db_down = d; db_left = l; db_right = r;
  endtask

  task automatic toggle_mode(input string tag);
    set_buttons(db_up, db_down, db_left, db_right, 1'b1);
    set_buttons(db_up, db_down, db_left, db_right, 1'b0);
    m_auto = !m_auto;
    check_state(tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".x"},    32'(pos_x),     32'd304);
    check({tag, ".y"},    32'(pos_y),     32'd224);
    check({tag, ".data"}, 32'(data),      32'hE0);
    check({tag, ".auto"}, 32'(auto_mode), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; frame_tick = 1'b0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_mode = 0;
    model_reset();

    // 1. Reset values.
    do_reset();
    check_reset_values("t1_reset");
    check_state("t1_model");

    // 2. Manual move right, then left+right cancel.
    set_buttons(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) do_tick($sformatf("t2_right%0d", i));
    check("t2_x310", 32'(pos_x), 32'd310);
    check("t2_y224", 32'(pos_y), 32'd224);
    set_buttons(0, 0, 1, 1, 0);
    do_tick("t2_both");
    check("t2_both_x", 32'(pos_x), 32'd310);

    // 3. Clamp at the left edge and ignore a short glitch.
    set_buttons(0, 0, 1, 0, 0);
    for (int i = 0; i < 160; i++) do_tick($sformatf("t3_left%0d", i));
    check("t3_x0", 32'(pos_x), 32'd0);
    set_buttons(0, 0, 0, 0, 0);
    @(posedge clk); #1 btn_up = 1'b1;
    repeat (2) @(posedge clk);
    #1 btn_up = 1'b0;
    repeat (D + 4) @(posedge clk);
    for (int i = 0; i < 3; i++) do_tick($sformatf("t3_glitch%0d", i));
    check("t3_y224", 32'(pos_y), 32'd224);

    // 4. Auto bounce from reset.
    do_reset();
    toggle_mode("t4_enter_auto");
    for (int k = 1; k <= 153; k++) begin
      do_tick($sformatf("t4_tick%0d", k));
      if (k == 112) begin
        check("t4_k112_y", 32'(pos_y), 32'd448);
        check("t4_k112_d", 32'(data),  32'hC1);
      end
      if (k == 152) begin
        check("t4_k152_x", 32'(pos_x), 32'd608);
        check("t4_k152_d", 32'(data),  32'h83);
      end
      if (k == 153) begin
        check("t4_k153_x", 32'(pos_x), 32'd606);
        check("t4_k153_y", 32'(pos_y), 32'd366);
      end
    end

    // 5. Mode edge coincident with frame_tick, in MANUAL while holding right.
    do_reset();
    set_buttons(0, 0, 0, 1, 0);
    @(posedge clk); #1 btn_mode = 1'b1;
    // The debounced level rises at the 6th edge, so the toggle lands on the 7th.
    repeat (D + 2) @(posedge clk);
    #1 frame_tick = 1'b1;
    model_tick();
    m_auto = 1;
    push_exp("t5_coincident");
    @(posedge clk); #1 frame_tick = 1'b0;
    pop_cmp();
    check("t5_x306",  32'(pos_x),     32'd306);
    check("t5_auto1", 32'(auto_mode), 32'd1);
    set_buttons(0, 0, 0, 0, 0);
    check_state("t5_retained");

    // 6. Reset coincident with a frame_tick while in AUTO.
    for (int i = 0; i < 3; i++) do_tick($sformatf("t6_auto%0d", i));
    @(posedge clk); #1;
    rst = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    check_reset_values("t6_reset");
    // Both directions must be positive again after reset.
    toggle_mode("t6_reenter_auto");
    do_tick("t6_dir_tick");
    check("t6_dir_x", 32'(pos_x), 32'd306);
    check("t6_dir_y", 32'(pos_y), 32'd226);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
